// File: rtl/alu_arb_defs.sv
// Shared definitions for the ALU share arbiter: state encodings, opcode
// constants and default widths.
package alu_arb_defs;

  localparam int WIDTH_DEF = 32;
  localparam int OPW_DEF   = 6;

  // Opcode whose zero flag is inverted by the ALU (flag=1 when result != 0)
  localparam logic [5:0] OP_ZERO_INV = 6'h22;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } arb_state_t;

endpackage

// File: rtl/alu_rr_pick.sv
// Two-input grant picker. Round-robin on last_grant by default; fixed
// priority (port 0 wins) when ALU_ARB_FIXED_PRIO_EN is defined.
module alu_rr_pick (
  input  logic valid0,
  input  logic valid1,
`ifndef ALU_ARB_FIXED_PRIO_EN
  input  logic last_grant,
`endif
  output logic gnt_any,
  output logic gnt_id
);

  always_comb begin
    gnt_any = valid0 | valid1;
`ifdef ALU_ARB_FIXED_PRIO_EN
    gnt_id  = valid1 & ~valid0;
`else
    // On a tie the port that did not win last time goes next
    gnt_id  = (valid0 & valid1) ? ~last_grant : valid1;
`endif
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational add/sub ALU between two requesters and holds the
// result in a one-entry response register. Macro: ALU_ARB_FIXED_PRIO_EN.
module alu_share_arbiter
  import alu_arb_defs::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int OPW   = OPW_DEF
) (
  input  logic             clk,
  input  logic             rst,

  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_main,
  input  logic [OPW-1:0]   req0_opcode,

  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_main,
  input  logic [OPW-1:0]   req1_opcode,

  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_main,
  output logic [OPW-1:0]   alu_opcode,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,

  output logic             resp_valid,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_result,
  output logic             resp_zero,
  input  logic             resp_ready
);

  arb_state_t state, state_d;
  logic       gnt_any;
  logic       gnt_id;
  logic       can_accept;
  logic       accept;

`ifndef ALU_ARB_FIXED_PRIO_EN
  logic       last_grant;
`endif

  alu_rr_pick u_pick (
    .valid0     (req0_valid),
    .valid1     (req1_valid),
`ifndef ALU_ARB_FIXED_PRIO_EN
    .last_grant (last_grant),
`endif
    .gnt_any    (gnt_any),
    .gnt_id     (gnt_id)
  );

  always_comb begin
    alu_a      = '0;
    alu_b      = '0;
    alu_main   = 1'b1;
    alu_opcode = '0;
    if (gnt_any) begin
      if (gnt_id) begin
        alu_a      = req1_a;
        alu_b      = req1_b;
        alu_main   = req1_main;
        alu_opcode = req1_opcode;
      end else begin
        alu_a      = req0_a;
        alu_b      = req0_b;
        alu_main   = req0_main;
        alu_opcode = req0_opcode;
      end
    end
  end

  // A held response can drain and be refilled in the same cycle
  always_comb begin
    can_accept = (state == ST_EMPTY) || resp_ready;
    accept     = can_accept && gnt_any && !rst;
    req0_ready = accept && (gnt_id == 1'b0);
    req1_ready = accept && (gnt_id == 1'b1);
    resp_valid = (state == ST_FULL);

    state_d = state;
    if (accept) begin
      state_d = ST_FULL;
    end else if ((state == ST_FULL) && resp_ready) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_d;
    end
  end

  // Response capture: data registers keep stale values once drained
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_id     <= 1'b0;
      resp_result <= '0;
      resp_zero   <= 1'b0;
    end else if (accept) begin
      resp_id     <= gnt_id;
      resp_result <= alu_result;
      resp_zero   <= alu_zero;
    end
  end

`ifndef ALU_ARB_FIXED_PRIO_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (accept) begin
      last_grant <= gnt_id;
    end
  end
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter with a behavioural ALU model.
module tb_alu_share_arbiter;

  localparam int W = 32;
  localparam int O = 6;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic         req0_ready, req1_ready;
  logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic         req0_main = 1'b1, req1_main = 1'b1;
  logic [O-1:0] req0_opcode = '0, req1_opcode = '0;
  logic [W-1:0] alu_a, alu_b, alu_result;
  logic         alu_main, alu_zero;
  logic [O-1:0] alu_opcode;
  logic         resp_valid, resp_id, resp_zero;
  logic [W-1:0] resp_result;
  logic         resp_ready = 1'b1;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct packed {
    logic         id;
    logic [W-1:0] result;
    logic         zero;
  } resp_t;

  resp_t sb_q[$];
  logic  m_full     = 1'b0;
  logic  m_last     = 1'b1;
  logic  m_post_rst = 1'b0;

  always #5 clk = ~clk;

  alu_share_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
    .req0_b(req0_b), .req0_main(req0_main), .req0_opcode(req0_opcode),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
    .req1_b(req1_b), .req1_main(req1_main), .req1_opcode(req1_opcode),
    .alu_a(alu_a), .alu_b(alu_b), .alu_main(alu_main), .alu_opcode(alu_opcode),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_result(resp_result),
    .resp_zero(resp_zero), .resp_ready(resp_ready)
  );

  function automatic logic [W-1:0] ref_result(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic m);
    return m ? (a + b) : (a - b);
  endfunction

  function automatic logic ref_zero(input logic [W-1:0] r, input logic [O-1:0] op);
    return (op == 6'h22) ? (r != '0) : (r == '0);
  endfunction

  // Behavioural ALU driven by the arbiter's operand lines
  always_comb begin
    alu_result = ref_result(alu_a, alu_b, alu_main);
    alu_zero   = ref_zero(alu_result, alu_opcode);
  end

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  always @(negedge clk) begin
    logic  e_any, e_id, e_acc;
    resp_t e;
    if (rst) begin
      check("ready0_rst", {31'b0, req0_ready}, 0);
      check("ready1_rst", {31'b0, req1_ready}, 0);
      m_full     = 1'b0;
      m_last     = 1'b1;
      m_post_rst = 1'b1;
      sb_q.delete();
    end else begin
      if (m_post_rst) begin
        check("rst_result", resp_result, 0);
        check("rst_id",     {31'b0, resp_id}, 0);
        check("rst_zero",   {31'b0, resp_zero}, 0);
        m_post_rst = 1'b0;
      end
      check("resp_valid", {31'b0, resp_valid}, {31'b0, m_full});
      if (m_full && sb_q.size() > 0) begin
        check("resp_id",     {31'b0, resp_id}, {31'b0, sb_q[0].id});
        check("resp_result", resp_result, sb_q[0].result);
        check("resp_zero",   {31'b0, resp_zero}, {31'b0, sb_q[0].zero});
      end
      e_any = req0_valid | req1_valid;
`ifdef ALU_ARB_FIXED_PRIO_EN
      e_id  = !req0_valid;
`else
      e_id  = (req0_valid && req1_valid) ? !m_last : req1_valid;
`endif
      e_acc = e_any && (!m_full || resp_ready);
      check("ready0", {31'b0, req0_ready}, {31'b0, e_acc && !e_id});
      check("ready1", {31'b0, req1_ready}, {31'b0, e_acc && e_id});
      if (m_full && resp_ready && sb_q.size() > 0) void'(sb_q.pop_front());
      if (e_acc) begin
        e.id     = e_id;
        e.result = e_id ? ref_result(req1_a, req1_b, req1_main)
                        : ref_result(req0_a, req0_b, req0_main);
        e.zero   = ref_zero(e.result, e_id ? req1_opcode : req0_opcode);
        sb_q.push_back(e);
        m_last = e_id;
      end
      m_full = e_acc || (m_full && !resp_ready);
    end
  end

  task automatic drive(input logic v0, input logic [W-1:0] a0, input logic [W-1:0] b0,
                       input logic m0, input logic [O-1:0] o0,
                       input logic v1, input logic [W-1:0] a1, input logic [W-1:0] b1,
                       input logic m1, input logic [O-1:0] o1, input logic rr);
    @(posedge clk);
    #1;
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_main = m0; req0_opcode = o0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_main = m1; req1_opcode = o1;
    resp_ready = rr;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    drive(1, 5, 3, 1, 0,  0, 0, 0, 1, 0,  1);
    drive(0, 0, 0, 1, 0,  0, 0, 0, 1, 0,  1);

    for (int i = 0; i < 4; i++)
      drive(1, 32'd100 + i, 32'd1, 1, 0,  1, 32'd200 + i, 32'd2, 0, 0,  1);
    drive(0, 0, 0, 1, 0,  0, 0, 0, 1, 0,  1);

    drive(0, 0, 0, 1, 0,  1, 7, 7, 0, 6'h22,  1);
    drive(0, 0, 0, 1, 0,  1, 7, 7, 0, 6'h00,  1);
    drive(0, 0, 0, 1, 0,  0, 0, 0, 1, 0,  1);

    drive(1, 9, 4, 0, 0,  0, 0, 0, 1, 0,  1);
    for (int i = 0; i < 3; i++)
      drive(1, 11, 22, 1, 0,  1, 33, 44, 1, 6'h22,  0);
    drive(1, 11, 22, 1, 0,  1, 33, 44, 1, 6'h22,  1);
    drive(1, 11, 22, 1, 0,  0, 0, 0, 1, 0,  1);

    drive(1, 0, 1, 0, 0,  0, 0, 0, 1, 0,  1);
    drive(0, 0, 0, 1, 0,  0, 0, 0, 1, 0,  0);

    drive(1, 1, 2, 1, 0,  1, 3, 4, 1, 0,  0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    drive(1, 1, 2, 1, 0,  1, 3, 4, 1, 0,  1);
    drive(1, 6, 6, 0, 0,  1, 8, 8, 0, 0,  1);
    drive(1, 6, 6, 0, 0,  1, 8, 8, 0, 0,  1);

    for (int i = 0; i < 60; i++)
      drive($urandom_range(0, 1), $urandom, $urandom_range(0, 3) == 0 ? 32'd0 : $urandom,
            $urandom_range(0, 1), $urandom_range(0, 1) ? 6'h22 : O'($urandom),
            $urandom_range(0, 1), $urandom, $urandom,
            $urandom_range(0, 1), $urandom_range(0, 1) ? 6'h22 : O'($urandom),
            $urandom_range(0, 3) != 0);

    drive(0, 0, 0, 1, 0,  0, 0, 0, 1, 0,  1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
